csr_rmw_unit: RTL and testbench



---
 rtl/csr_pkg.sv | 26 ++
 rtl/csr_rmw_alu.sv | 23 ++
 rtl/csr_rmw_unit.sv | 128 ++++++++++++
 tb/tb_csr_rmw_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared types for the CSR read-modify-write unit: op encoding, FSM states and
// the read-only address-space test.
package csr_pkg;

  localparam int unsigned CSR_ADDR_W = 12;

  typedef enum logic [1:0] {
    ILLEGAL = 2'b00,
    RW      = 2'b01,
    RS      = 2'b10,
    RC      = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    READ = 2'b01,
    MOD  = 2'b10,
    RESP = 2'b11
  } csr_state_e;

  // Top two address bits both set marks the read-only CSR space.
  function automatic logic is_csr_ro(input logic [CSR_ADDR_W-1:0] addr);
    return addr[CSR_ADDR_W-1 -: 2] == 2'b11;
  endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// Combinational modify step: combines the old CSR value with the operand
// according to the op (write, set bits, clear bits).
module csr_rmw_alu
  import csr_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  csr_op_e           i_op,
  input  logic [DATA_W-1:0] i_old,
  input  logic [DATA_W-1:0] i_operand,
  output logic [DATA_W-1:0] o_new
);

  always_comb begin
    o_new = i_operand;
    case (i_op)
      RS:      o_new = i_old | i_operand;
      RC:      o_new = i_old & ~i_operand;
      default: o_new = i_operand;
    endcase
  end

endmodule

// File: rtl/csr_rmw_unit.sv
// Zicsr read-modify-write sequencer between execute and CSR storage.
// States: IDLE accept | READ read strobe | MOD modify+write | RESP hold response.
module csr_rmw_unit
  import csr_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter bit RO_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_operand,
  input  logic              req_no_read,
  input  logic              req_no_write,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_illegal,
  output logic              csr_read,
  output logic [ADDR_W-1:0] csr_read_addr,
  input  logic [DATA_W-1:0] csr_read_data,
  output logic              csr_write,
  output logic [ADDR_W-1:0] csr_write_addr,
  output logic [DATA_W-1:0] csr_write_data
);

  csr_state_e        r_state, w_state_nxt;
  csr_op_e           r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_operand;
  logic [DATA_W-1:0] r_rdata;
  logic              r_do_write, r_do_read, r_illegal;

  csr_op_e           w_op;
  logic              w_accept, w_do_write, w_do_read, w_illegal;
  logic [DATA_W-1:0] w_old, w_new;

  assign w_op       = csr_op_e'(req_op);
  assign w_accept   = req_valid && (r_state == IDLE);
  assign w_do_write = (w_op == RW) || !req_no_write;
  assign w_do_read  = !req_no_read || (w_op != RW);
  assign w_illegal  = (w_op == ILLEGAL) ||
                      (RO_CHECK && w_do_write && is_csr_ro(req_addr[CSR_ADDR_W-1:0]));

  // A skipped read (RW with rd==x0) contributes an old value of zero.
  assign w_old = r_do_read ? csr_read_data : '0;

  csr_rmw_alu #(.DATA_W(DATA_W)) u_alu (
    .i_op     (r_op),
    .i_old    (w_old),
    .i_operand(r_operand),
    .o_new    (w_new)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_op       <= ILLEGAL;
      r_addr     <= '0;
      r_operand  <= '0;
      r_rdata    <= '0;
      r_do_write <= 1'b0;
      r_do_read  <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op       <= w_op;
        r_addr     <= req_addr;
        r_operand  <= req_operand;
        r_do_write <= w_do_write;
        r_do_read  <= w_do_read;
        r_illegal  <= w_illegal;
        r_rdata    <= '0;
      end else if (r_state == MOD) begin
        r_rdata <= w_old;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    rsp_rdata      = '0;
    rsp_illegal    = 1'b0;
    csr_read       = 1'b0;
    csr_read_addr  = '0;
    csr_write      = 1'b0;
    csr_write_addr = '0;
    csr_write_data = '0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_illegal)       w_state_nxt = RESP;
          else if (!w_do_read) w_state_nxt = MOD;
          else                 w_state_nxt = READ;
        end
      end
      READ: begin
        csr_read      = 1'b1;
        csr_read_addr = r_addr;
        w_state_nxt   = MOD;
      end
      MOD: begin
        if (r_do_write) begin
          csr_write      = 1'b1;
          csr_write_addr = r_addr;
          csr_write_data = w_new;
        end
        w_state_nxt = RESP;
      end
      RESP: begin
        rsp_valid   = 1'b1;
        rsp_rdata   = r_rdata;
        rsp_illegal = r_illegal;
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_rmw_unit.sv
// Directed bench for csr_rmw_unit: CSR memory model, behavioural RMW model and
// a per-cycle monitor of strobes and response.
module tb_csr_rmw_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [11:0] req_addr = '0;
  logic [31:0] req_operand = '0;
  logic        req_no_read = 1'b0, req_no_write = 1'b0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_illegal;
  logic [31:0] rsp_rdata;
  logic        csr_read, csr_write;
  logic [11:0] csr_read_addr, csr_write_addr;
  logic [31:0] csr_read_data, csr_write_data;

  always #5 clk = ~clk;

  csr_rmw_unit #(.ADDR_W(12), .DATA_W(32), .RO_CHECK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_operand(req_operand),
    .req_no_read(req_no_read), .req_no_write(req_no_write),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_illegal(rsp_illegal),
    .csr_read(csr_read), .csr_read_addr(csr_read_addr), .csr_read_data(csr_read_data),
    .csr_write(csr_write), .csr_write_addr(csr_write_addr), .csr_write_data(csr_write_data)
  );

  // CSR storage: registered read, synchronous write
  logic [31:0] mem [0:4095];
  logic [31:0] model_mem [0:4095];
  logic [31:0] rd_q = '0;
  always @(posedge clk) begin
    if (csr_write) mem[csr_write_addr] <= csr_write_data;
    if (csr_read)  rd_q <= mem[csr_read_addr];
  end
  assign csr_read_data = rd_q;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // expectations for the operation in flight
  logic [11:0] e_addr = '0;
  logic [31:0] e_new = '0, e_rdata = '0;
  logic        e_illegal = 1'b0;
  int          e_lat = 0, e_rd = 0, e_wr = 0;
  int          rd_cnt = 0, wr_cnt = 0;

  task automatic model(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] operand,
                       input logic nr, input logic nw);
    logic        wants_write, reads, writes, illegal;
    logic [31:0] old;
    wants_write = (op == 2'b01) || !nw;
    illegal     = (op == 2'b00) || (wants_write && addr[11:10] == 2'b11);
    reads       = !illegal && (!nr || op != 2'b01);
    writes      = !illegal && wants_write;
    old         = reads ? model_mem[addr] : 32'h0;
    case (op)
      2'b10:   e_new = old | operand;
      2'b11:   e_new = old & ~operand;
      default: e_new = operand;
    endcase
    e_addr    = addr;
    e_rdata   = illegal ? 32'h0 : old;
    e_illegal = illegal;
    e_lat     = illegal ? 1 : (reads ? 3 : 2);
    e_rd      = reads ? 1 : 0;
    e_wr      = writes ? 1 : 0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("rd_wr_excl", {31'b0, csr_read & csr_write}, 32'h0);
      if (csr_read) begin
        chk("rd_addr", {20'b0, csr_read_addr}, {20'b0, e_addr});
        rd_cnt++;
      end else chk("rd_addr_idle", {20'b0, csr_read_addr}, 32'h0);
      if (csr_write) begin
        chk("wr_addr", {20'b0, csr_write_addr}, {20'b0, e_addr});
        chk("wr_data", csr_write_data, e_new);
        wr_cnt++;
      end else begin
        chk("wr_addr_idle", {20'b0, csr_write_addr}, 32'h0);
        chk("wr_data_idle", csr_write_data, 32'h0);
      end
      if (rsp_valid) begin
        chk("rsp_rdata", rsp_rdata, e_rdata);
        chk("rsp_illegal", {31'b0, rsp_illegal}, {31'b0, e_illegal});
        chk("req_ready_busy", {31'b0, req_ready}, 32'h0);
      end
    end
  end

  task automatic wait_ready();
    int w = 0;
    while (!req_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk("req_ready_idle", {31'b0, req_ready}, 32'h1);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] operand,
                        input logic nr, input logic nw, input int hold, output logic [31:0] got);
    int lat;
    model(op, addr, operand, nr, nw);
    rd_cnt = 0; wr_cnt = 0;
    wait_ready();
    req_valid = 1'b1; req_op = op; req_addr = addr; req_operand = operand;
    req_no_read = nr; req_no_write = nw;
    rsp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_operand = '0;
    req_no_read = 1'b0; req_no_write = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, e_lat);
    got = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", {31'b0, rsp_valid}, 32'h1);
      chk("hold_rdata", rsp_rdata, got);
      chk("hold_req_ready", {31'b0, req_ready}, 32'h0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_done", {31'b0, rsp_valid}, 32'h0);
    chk("ready_after", {31'b0, req_ready}, 32'h1);
    chk("rd_count", rd_cnt, e_rd);
    chk("wr_count", wr_cnt, e_wr);
    if (e_wr == 1) model_mem[addr] = e_new;
    chk("mem", mem[addr], model_mem[addr]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 32'h0;
      model_mem[i] = 32'h0;
    end
    mem[12'h300] = 32'h0000_00F0; model_mem[12'h300] = 32'h0000_00F0;
    mem[12'hC00] = 32'h1234_5678; model_mem[12'hC00] = 32'h1234_5678;

    #12;
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_csr_read", {31'b0, csr_read}, 32'h0);
    chk("rst_csr_write", {31'b0, csr_write}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op(2'b10, 12'h300, 32'h0000_000F, 1'b0, 1'b0, 0, got);
    chk("rs_rdata_lit", got, 32'h0000_00F0);
    chk("rs_mem_lit", mem[12'h300], 32'h0000_00FF);

    run_op(2'b11, 12'h300, 32'h0000_0081, 1'b0, 1'b0, 0, got);
    chk("rc_rdata_lit", got, 32'h0000_00FF);
    chk("rc_mem_lit", mem[12'h300], 32'h0000_007E);

    run_op(2'b01, 12'h340, 32'hDEAD_BEEF, 1'b1, 1'b0, 0, got);
    chk("rw_noread_rdata_lit", got, 32'h0);
    chk("rw_noread_mem_lit", mem[12'h340], 32'hDEAD_BEEF);

    run_op(2'b10, 12'hC00, 32'h0000_0000, 1'b0, 1'b1, 0, got);
    chk("ro_read_rdata_lit", got, 32'h1234_5678);
    chk("ro_read_mem_lit", mem[12'hC00], 32'h1234_5678);

    run_op(2'b01, 12'hC00, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, got);
    chk("ro_write_rdata_lit", got, 32'h0);
    chk("ro_write_mem_lit", mem[12'hC00], 32'h1234_5678);

    run_op(2'b00, 12'h300, 32'h1111_1111, 1'b0, 1'b0, 0, got);
    chk("op00_mem_lit", mem[12'h300], 32'h0000_007E);

    run_op(2'b11, 12'h340, 32'hFFFF_0000, 1'b0, 1'b1, 0, got);
    chk("rc_nowrite_rdata_lit", got, 32'hDEAD_BEEF);

    run_op(2'b01, 12'h300, 32'h0000_A5A5, 1'b0, 1'b0, 5, got);
    chk("rw_hold_rdata_lit", got, 32'h0000_007E);
    chk("rw_hold_mem_lit", mem[12'h300], 32'h0000_A5A5);

    // reset while the write strobe is up: the write must not land
    model(2'b10, 12'h300, 32'h0000_0100, 1'b0, 1'b0);
    wait_ready();
    req_valid = 1'b1; req_op = 2'b10; req_addr = 12'h300; req_operand = 32'h0000_0100;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_operand = '0;
    @(posedge clk); #1;
    chk("mod_write_up", {31'b0, csr_write}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_write_drop", {31'b0, csr_write}, 32'h0);
    chk("rst_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_no_rsp", {31'b0, rsp_valid}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_mem_lit", mem[12'h300], 32'h0000_A5A5);

    run_op(2'b10, 12'h300, 32'h5A5A_0000, 1'b0, 1'b0, 0, got);
    chk("post_rst_rdata_lit", got, 32'h0000_A5A5);
    chk("post_rst_mem_lit", mem[12'h300], 32'h5A5A_A5A5);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
